// File: rtl/waveform_dm_sequencer_if.sv
// Datamover command/status stream bundle for waveform_dm_sequencer.
// master: sequencer side (drives commands, accepts status).
// slave : datamover side (accepts commands, returns status, drives error pins).
//   s2mm_cmd_* / mm2s_cmd_* : 72-bit command streams
//   s2mm_sts_* / mm2s_sts_* : 8-bit status streams
//   s2mm_err / mm2s_err     : datamover error pins
interface waveform_dm_sequencer_if;
    logic [71:0] s2mm_cmd_tdata;
    logic        s2mm_cmd_tvalid;
    logic        s2mm_cmd_tready;
    logic [7:0]  s2mm_sts_tdata;
    logic        s2mm_sts_tvalid;
    logic        s2mm_sts_tready;
    logic [71:0] mm2s_cmd_tdata;
    logic        mm2s_cmd_tvalid;
    logic        mm2s_cmd_tready;
    logic [7:0]  mm2s_sts_tdata;
    logic        mm2s_sts_tvalid;
    logic        mm2s_sts_tready;
    logic        s2mm_err;
    logic        mm2s_err;

    modport master (
        output s2mm_cmd_tdata, s2mm_cmd_tvalid, input s2mm_cmd_tready,
        input  s2mm_sts_tdata, s2mm_sts_tvalid, output s2mm_sts_tready,
        output mm2s_cmd_tdata, mm2s_cmd_tvalid, input mm2s_cmd_tready,
        input  mm2s_sts_tdata, mm2s_sts_tvalid, output mm2s_sts_tready,
        input  s2mm_err, mm2s_err
    );

    modport slave (
        input  s2mm_cmd_tdata, s2mm_cmd_tvalid, output s2mm_cmd_tready,
        output s2mm_sts_tdata, s2mm_sts_tvalid, input s2mm_sts_tready,
        input  mm2s_cmd_tdata, mm2s_cmd_tvalid, output mm2s_cmd_tready,
        output mm2s_sts_tdata, mm2s_sts_tvalid, input mm2s_sts_tready,
        output s2mm_err, mm2s_err
    );
endinterface

// File: rtl/waveform_dm_sequencer.sv
// Command sequencer for the waveform BRAM datamover. Turns load (S2MM) and playback (MM2S)
// requests into 72-bit datamover commands, checks returned status, repeats playback for
// rd_repeat passes (0 = until rd_stop), arbitrates load over play and latches errors.
// Ports:
//   i_clk_in1, i_reset (sync, active-high)
//   i_wr_req/i_wr_addr/i_wr_btt          load request
//   i_rd_req/i_rd_addr/i_rd_btt/i_rd_repeat/i_rd_stop  playback request and stop
//   o_req_ack, o_done, o_busy, o_pass_cnt status to control logic
//   o_err, o_err_cause, o_err_sts, i_clear_err        sticky error reporting
//   io_dm                                 datamover streams (master modport)
// Optional: define WFM_DM_TIMEOUT_EN to add a status watchdog (TIMEOUT_CYCLES, cause 5).
module waveform_dm_sequencer #(
    parameter int unsigned BTT_WIDTH    = 23,
    parameter int unsigned REPEAT_WIDTH = 16
`ifdef WFM_DM_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                    i_clk_in1,
    input  logic                    i_reset,
    input  logic                    i_wr_req,
    input  logic [31:0]             i_wr_addr,
    input  logic [BTT_WIDTH-1:0]    i_wr_btt,
    input  logic                    i_rd_req,
    input  logic [31:0]             i_rd_addr,
    input  logic [BTT_WIDTH-1:0]    i_rd_btt,
    input  logic [REPEAT_WIDTH-1:0] i_rd_repeat,
    input  logic                    i_rd_stop,
    output logic                    o_req_ack,
    output logic                    o_done,
    output logic                    o_busy,
    output logic [REPEAT_WIDTH-1:0] o_pass_cnt,
    output logic                    o_err,
    output logic [2:0]              o_err_cause,
    output logic [7:0]              o_err_sts,
    input  logic                    i_clear_err,
    waveform_dm_sequencer_if.master io_dm
);
    typedef enum logic [2:0] {StIdle, StWrCmd, StWrSts, StRdCmd, StRdSts, StErr} state_e;

    localparam logic [2:0] CauseBadSts = 3'd1;
    localparam logic [2:0] CauseTag    = 3'd2;
    localparam logic [2:0] CauseZero   = 3'd3;
    localparam logic [2:0] CausePin    = 3'd4;
    localparam logic [2:0] CauseTmo    = 3'd5;

    state_e                  r_state, w_state_next;
    logic [31:0]             r_addr;
    logic [BTT_WIDTH-1:0]    r_btt;
    logic [REPEAT_WIDTH-1:0] r_repeat, r_pass_cnt;
    logic [3:0]              r_tag, r_exp_tag;
    logic                    r_stop, r_done, r_err;
    logic [2:0]              r_err_cause;
    logic [7:0]              r_err_sts;

    logic                    w_req_ack, w_cmd_hs, w_done, w_pass_inc, w_set_err, w_timeout;
    logic [2:0]              w_cause, w_sts_cause;
    logic [7:0]              w_sts, w_err_sts;
    logic [BTT_WIDTH-1:0]    w_req_btt;
    logic [REPEAT_WIDTH:0]   w_pass_plus;
    logic                    w_stop, w_last_pass;

    // Stop may arrive in the same cycle as the final status handshake.
    assign w_stop      = r_stop | i_rd_stop;
    assign w_pass_plus = {1'b0, r_pass_cnt} + 1'b1;
    assign w_last_pass = (r_repeat != '0) && (w_pass_plus == {1'b0, r_repeat});
    assign w_req_btt   = i_wr_req ? i_wr_btt : i_rd_btt;
    assign w_sts       = (r_state == StWrSts) ? io_dm.s2mm_sts_tdata : io_dm.mm2s_sts_tdata;
    // Tag mismatch outranks a bad OK/error field.
    assign w_sts_cause = (w_sts[3:0] != r_exp_tag) ? CauseTag :
                         (!w_sts[7] || (w_sts[6:4] != 3'd0)) ? CauseBadSts : 3'd0;

`ifdef WFM_DM_TIMEOUT_EN
    logic [31:0] r_timer;
    always_ff @(posedge i_clk_in1) begin
        if (i_reset) begin
            r_timer <= '0;
        end else if ((w_state_next != r_state) || !(r_state inside {StWrSts, StRdSts})) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end
    assign w_timeout = (r_state inside {StWrSts, StRdSts}) && (r_timer == TIMEOUT_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_req_ack    = 1'b0;
        w_cmd_hs     = 1'b0;
        w_done       = 1'b0;
        w_pass_inc   = 1'b0;
        w_set_err    = 1'b0;
        w_cause      = 3'd0;
        w_err_sts    = 8'd0;
        unique case (r_state)
            StIdle: begin
                if (i_wr_req || i_rd_req) begin
                    w_req_ack = 1'b1;
                    if (w_req_btt == '0) begin
                        w_set_err    = 1'b1;
                        w_cause      = CauseZero;
                        w_state_next = StErr;
                    end else begin
                        w_state_next = i_wr_req ? StWrCmd : StRdCmd;
                    end
                end
            end
            StWrCmd: begin
                if (io_dm.s2mm_cmd_tready) begin
                    w_cmd_hs     = 1'b1;
                    w_state_next = StWrSts;
                end
            end
            StRdCmd: begin
                if (io_dm.mm2s_cmd_tready) begin
                    w_cmd_hs     = 1'b1;
                    w_state_next = StRdSts;
                end
            end
            StWrSts, StRdSts: begin
                if ((r_state == StWrSts) ? io_dm.s2mm_sts_tvalid : io_dm.mm2s_sts_tvalid) begin
                    if (w_sts_cause != 3'd0) begin
                        w_set_err    = 1'b1;
                        w_cause      = w_sts_cause;
                        w_err_sts    = w_sts;
                        w_state_next = StErr;
                    end else if (r_state == StWrSts) begin
                        w_done       = 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_pass_inc = 1'b1;
                        if (w_stop || w_last_pass) begin
                            w_done       = 1'b1;
                            w_state_next = StIdle;
                        end else begin
                            w_state_next = StRdCmd;
                        end
                    end
                end else if (w_timeout) begin
                    w_set_err    = 1'b1;
                    w_cause      = CauseTmo;
                    w_state_next = StErr;
                end
            end
            StErr: begin
                if (i_clear_err) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase

        // Datamover error pins override any same-cycle status result.
        if ((r_state inside {StWrCmd, StWrSts, StRdCmd, StRdSts}) &&
            (io_dm.s2mm_err || io_dm.mm2s_err)) begin
            w_set_err    = 1'b1;
            w_cause      = CausePin;
            w_err_sts    = 8'd0;
            w_done       = 1'b0;
            w_pass_inc   = 1'b0;
            w_state_next = StErr;
        end
    end

    always_ff @(posedge i_clk_in1) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_btt       <= '0;
            r_repeat    <= '0;
            r_pass_cnt  <= '0;
            r_tag       <= '0;
            r_exp_tag   <= '0;
            r_stop      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_cause <= 3'd0;
            r_err_sts   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done;
            if (w_req_ack) begin
                r_addr     <= i_wr_req ? i_wr_addr : i_rd_addr;
                r_btt      <= w_req_btt;
                r_repeat   <= i_rd_repeat;
                r_pass_cnt <= '0;
            end
            if (w_cmd_hs) begin
                r_exp_tag <= r_tag;
                r_tag     <= r_tag + 4'd1;
            end
            if (w_pass_inc && !(&r_pass_cnt)) begin
                r_pass_cnt <= r_pass_cnt + 1'b1;
            end
            if (w_state_next == StIdle) begin
                r_stop <= 1'b0;
            end else if ((r_state inside {StRdCmd, StRdSts}) && i_rd_stop) begin
                r_stop <= 1'b1;
            end
            if (w_set_err) begin
                r_err       <= 1'b1;
                r_err_cause <= w_cause;
                r_err_sts   <= w_err_sts;
            end else if ((r_state == StErr) && i_clear_err) begin
                r_err       <= 1'b0;
                r_err_cause <= 3'd0;
                r_err_sts   <= 8'd0;
            end
        end
    end

    // One command word serves both streams; only the tvalid differs.
    logic [71:0] w_cmd;
    assign w_cmd = {4'h0, r_tag, r_addr, 1'b0, 1'b1, 6'd0, 1'b1, 23'(r_btt)};

    assign io_dm.s2mm_cmd_tdata  = w_cmd;
    assign io_dm.mm2s_cmd_tdata  = w_cmd;
    assign io_dm.s2mm_cmd_tvalid = (r_state == StWrCmd);
    assign io_dm.mm2s_cmd_tvalid = (r_state == StRdCmd);
    assign io_dm.s2mm_sts_tready = (r_state == StWrSts) || (r_state == StErr);
    assign io_dm.mm2s_sts_tready = (r_state == StRdSts) || (r_state == StErr);

    assign o_req_ack   = w_req_ack;
    assign o_done      = r_done;
    assign o_busy      = (r_state != StIdle);
    assign o_pass_cnt  = r_pass_cnt;
    assign o_err       = r_err;
    assign o_err_cause = r_err_cause;
    assign o_err_sts   = r_err_sts;
endmodule

// File: tb/tb_waveform_dm_sequencer.sv
// Self-checking bench for waveform_dm_sequencer: the bench plays the datamover, pushes the
// expected command/done/error events into a queue, and a monitor compares DUT events in order.
module tb_waveform_dm_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, rd_req, rd_stop, clear_err;
    logic [31:0] wr_addr, rd_addr;
    logic [22:0] wr_btt, rd_btt;
    logic [15:0] rd_repeat;
    logic        req_ack, done, busy, err;
    logic [15:0] pass_cnt;
    logic [2:0]  err_cause;
    logic [7:0]  err_sts;

    always #5 clk = ~clk;

    waveform_dm_sequencer_if dm ();

    waveform_dm_sequencer dut (
        .i_clk_in1   (clk),
        .i_reset     (rst),
        .i_wr_req    (wr_req),
        .i_wr_addr   (wr_addr),
        .i_wr_btt    (wr_btt),
        .i_rd_req    (rd_req),
        .i_rd_addr   (rd_addr),
        .i_rd_btt    (rd_btt),
        .i_rd_repeat (rd_repeat),
        .i_rd_stop   (rd_stop),
        .o_req_ack   (req_ack),
        .o_done      (done),
        .o_busy      (busy),
        .o_pass_cnt  (pass_cnt),
        .o_err       (err),
        .o_err_cause (err_cause),
        .o_err_sts   (err_sts),
        .i_clear_err (clear_err),
        .io_dm       (dm)
    );

    // Event kinds: 0 s2mm cmd, 1 mm2s cmd, 2 done (data = pass_cnt), 3 err ({cause, sts}).
    typedef struct {
        int          kind;
        logic [71:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] m_tag   = 4'd0;
    bit         prev_err = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [71:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    function automatic logic [71:0] cmd_word(input logic [31:0] a, input logic [22:0] b,
                                             input logic [3:0] t);
        return {4'h0, t, a, 1'b0, 1'b1, 6'd0, 1'b1, b};
    endfunction

    task automatic mon(input int kind, input logic [71:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected event: got kind %0d data %h, expected no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("event(kind %0d)", e.kind), {8'(kind), data}, {8'(e.kind), e.data});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dm.s2mm_cmd_tvalid && dm.s2mm_cmd_tready) mon(0, dm.s2mm_cmd_tdata);
            if (dm.mm2s_cmd_tvalid && dm.mm2s_cmd_tready) mon(1, dm.mm2s_cmd_tdata);
            if (done) mon(2, 72'(pass_cnt));
            if (err && !prev_err) mon(3, 72'({err_cause, err_sts}));
        end
        prev_err = err;
    end

    function automatic bit probe(input int code);
        case (code)
            0:       return req_ack;
            1:       return dm.s2mm_cmd_tvalid;
            2:       return dm.mm2s_cmd_tvalid;
            default: return err;
        endcase
    endfunction

    task automatic wait_for(input int code, input string what, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (probe(code)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout %s: not seen in 200 cycles, required within bound", what);
        end
    endtask

    task automatic issue(input bit w, input bit r);
        bit ok;
        @(posedge clk);
        #1;
        if (w) wr_req = 1'b1;
        if (r) rd_req = 1'b1;
        wait_for(0, "req_ack", ok);
        @(posedge clk);
        #1;
        if (w) wr_req = 1'b0;
        else   rd_req = 1'b0;
    endtask

    task automatic dm_cmd(input bit rd, input bit stop);
        bit ok;
        wait_for(rd ? 2 : 1, rd ? "mm2s cmd tvalid" : "s2mm cmd tvalid", ok);
        if (!ok) return;
        if (stop) begin
            @(posedge clk);
            #1 rd_stop = 1'b1;
            @(posedge clk);
            #1 rd_stop = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
        @(posedge clk);
        #1;
        if (rd) dm.mm2s_cmd_tready = 1'b1;
        else    dm.s2mm_cmd_tready = 1'b1;
        @(posedge clk);
        #1;
        dm.mm2s_cmd_tready = 1'b0;
        dm.s2mm_cmd_tready = 1'b0;
    endtask

    task automatic dm_sts(input bit rd, input logic [7:0] s);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1;
        if (rd) begin
            dm.mm2s_sts_tdata  = s;
            dm.mm2s_sts_tvalid = 1'b1;
        end else begin
            dm.s2mm_sts_tdata  = s;
            dm.s2mm_sts_tvalid = 1'b1;
        end
        @(posedge clk);
        #1;
        dm.mm2s_sts_tvalid = 1'b0;
        dm.s2mm_sts_tvalid = 1'b0;
    endtask

    task automatic recover();
        bit ok;
        wait_for(3, "err", ok);
        @(posedge clk);
        #1 clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
        @(negedge clk);
        check("err cleared {err,busy,cause,sts}", 80'({err, busy, err_cause, err_sts}), 80'd0);
    endtask

    // bad: 0 ok, 1 bad status, 2 tag mismatch, 4 error pin.
    task automatic finish_sts(input bit rd, input int bad, input logic [3:0] t,
                              input int pass, input bit last);
        logic [3:0] u;
        logic [7:0] s;
        case (bad)
            0: begin
                if (last) push(2, 72'(pass));
                dm_sts(rd, {4'h8, t});
            end
            1: begin
                do u = 4'($urandom_range(0, 15)); while (u[3] && u[2:0] == 3'd0);
                s = {u, t};
                push(3, 72'({3'd1, s}));
                dm_sts(rd, s);
            end
            2: begin
                s = {4'($urandom_range(0, 15)), t ^ 4'($urandom_range(1, 15))};
                push(3, 72'({3'd2, s}));
                dm_sts(rd, s);
            end
            default: begin
                push(3, 72'({3'd4, 8'h00}));
                @(posedge clk);
                #1;
                if (rd) dm.mm2s_err = 1'b1;
                else    dm.s2mm_err = 1'b1;
                @(posedge clk);
                #1;
                dm.mm2s_err = 1'b0;
                dm.s2mm_err = 1'b0;
            end
        endcase
        if (bad != 0) recover();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [22:0] b, input int bad,
                            input bit both);
        wr_addr = a;
        wr_btt  = b;
        if (b == 23'd0) begin
            push(3, 72'({3'd3, 8'h00}));
            issue(1'b1, both);
            recover();
            return;
        end
        push(0, cmd_word(a, b, m_tag));
        m_tag++;
        issue(1'b1, both);
        dm_cmd(1'b0, 1'b0);
        finish_sts(1'b0, bad, m_tag - 4'd1, 0, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [22:0] b, input logic [15:0] rep,
                           input int stop_pass, input int bad_pass, input int bad_kind,
                           input bit pending);
        bit         ok;
        int         n;
        logic [3:0] t;
        rd_addr   = a;
        rd_btt    = b;
        rd_repeat = rep;
        if (b == 23'd0) begin
            push(3, 72'({3'd3, 8'h00}));
            issue(1'b0, 1'b1);
            recover();
            return;
        end
        if (rep == 16'd0) n = stop_pass;
        else if (stop_pass != 0 && stop_pass < int'(rep)) n = stop_pass;
        else n = int'(rep);
        if (pending) begin
            wait_for(0, "pending rd req_ack", ok);
            @(posedge clk);
            #1 rd_req = 1'b0;
        end else begin
            issue(1'b0, 1'b1);
        end
        for (int p = 1; p <= n; p++) begin
            push(1, cmd_word(a, b, m_tag));
            t = m_tag;
            m_tag++;
            dm_cmd(1'b1, p == stop_pass);
            if (p == bad_pass) begin
                finish_sts(1'b1, bad_kind, t, 0, 1'b0);
                return;
            end
            finish_sts(1'b1, 0, t, p, p == n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        int       sel, rep, sp, bp, bk;
        logic [22:0] b;
        rst = 1'b1;
        {wr_req, rd_req, rd_stop, clear_err} = 4'b0;
        wr_addr = '0; rd_addr = '0; wr_btt = '0; rd_btt = '0; rd_repeat = '0;
        dm.s2mm_cmd_tready = 1'b0; dm.mm2s_cmd_tready = 1'b0;
        dm.s2mm_sts_tvalid = 1'b0; dm.mm2s_sts_tvalid = 1'b0;
        dm.s2mm_sts_tdata  = '0;   dm.mm2s_sts_tdata  = '0;
        dm.s2mm_err = 1'b0; dm.mm2s_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy/err/done/ack", 80'({busy, err, done, req_ack}), 80'd0);
        check("reset pass_cnt", 80'(pass_cnt), 80'd0);
        check("reset err_cause/err_sts", 80'({err_cause, err_sts}), 80'd0);
        check("reset cmd tvalids", 80'({dm.s2mm_cmd_tvalid, dm.mm2s_cmd_tvalid}), 80'd0);
        check("reset sts treadys", 80'({dm.s2mm_sts_tready, dm.mm2s_sts_tready}), 80'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Known-good load: exact command word from the datasheet example.
        wr_addr = 32'h0000_1000;
        wr_btt  = 23'd4096;
        push(0, 72'h0_0_0000_1000_40801000);
        m_tag++;
        issue(1'b1, 1'b0);
        dm_cmd(1'b0, 1'b0);
        push(2, 72'd0);
        dm_sts(1'b0, 8'h80);
        @(negedge clk);
        check("busy low after load", 80'(busy), 80'd0);

        do_read(32'h0000_2000, 23'd256, 16'd3, 0, 0, 0, 1'b0);
        check("pass_cnt after 3 passes", 80'(pass_cnt), 80'd3);

        // Load and play requested together: load first, play served afterwards.
        rd_addr = 32'h0000_3000; rd_btt = 23'd64; rd_repeat = 16'd2;
        do_write(32'h0000_4000, 23'd128, 0, 1'b1);
        do_read(32'h0000_3000, 23'd64, 16'd2, 0, 0, 0, 1'b1);

        do_read(32'h0001_0000, 23'd512, 16'd0, 5, 0, 0, 1'b0);
        check("pass_cnt after stop on pass 5", 80'(pass_cnt), 80'd5);

        do_write(32'h0000_5000, 23'd32, 1, 1'b0);
        do_write(32'h0000_6000, 23'd32, 2, 1'b0);
        do_write(32'h0000_7000, 23'd0, 0, 1'b0);
        do_read(32'h0000_8000, 23'd0, 16'd1, 0, 0, 0, 1'b0);
        do_read(32'h0000_9000, 23'd16, 16'd3, 0, 2, 4, 1'b0);

        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 9);
            b   = ($urandom_range(0, 9) == 0) ? 23'd0 : 23'($urandom_range(1, 23'h7F_FFFF));
            if (sel < 4) begin
                bk = $urandom_range(0, 5);
                do_write($urandom, b, (bk > 2) ? 0 : (bk == 0 ? 4 : bk), 1'b0);
            end else begin
                rep = $urandom_range(0, 4);
                sp  = (rep == 0) ? $urandom_range(1, 4) : $urandom_range(0, 3);
                bp  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
                bk  = $urandom_range(0, 2);
                do_read($urandom, b, 16'(rep), sp, bp, (bk == 0) ? 4 : bk, 1'b0);
            end
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard queue drained", 80'(exp_q.size()), 80'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
